// File: rtl/mcu_wr_sync_if.sv
// MCU bus pins plus the decoded command outputs of mcu_wr_sync.
// The MCU side drives the strobes and bus; the write port drives the command outputs.
interface mcu_wr_sync_if #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 16,
    parameter int unsigned NUM_CH = 8
);
    logic                   CS;
    logic                   WR;
    logic [AW-1:0]          MCUportL;
    logic [DW-1:0]          Din;
    logic [NUM_CH*DW-1:0]   gStateCmd;
    logic [DW-1:0]          gPlsCmd;
    logic                   pls_valid;
    logic [NUM_CH-1:0]      state_upd;
    logic                   wr_err;

    modport master (
        output CS, WR, MCUportL, Din,
        input  gStateCmd, gPlsCmd, pls_valid, state_upd, wr_err
    );

    modport slave (
        input  CS, WR, MCUportL, Din,
        output gStateCmd, gPlsCmd, pls_valid, state_upd, wr_err
    );
endinterface

// File: rtl/mcu_wr_sync.sv
// Clocked MCU write port: synchronises the asynchronous WR|CS strobe and decodes
// committed writes into channel state registers, a timed pulse command and an error flag.
module mcu_wr_sync #(
    parameter int unsigned   DW          = 8,
    parameter int unsigned   AW          = 16,
    parameter int unsigned   NUM_CH      = 8,
    parameter int unsigned   SYNC_STAGES = 2,
    parameter int unsigned   PLS_HOLD    = 1,
    parameter logic [AW-1:0] PLS_ADDR    = 'h0001,
    parameter logic [AW-1:0] CLR_ADDR    = 'h0002,
    parameter logic [AW-1:0] STATE_BASE  = 'h0010
) (
    input  logic         CLK,
    input  logic         nRST,
    mcu_wr_sync_if.slave bus
);

    localparam int unsigned   HCW       = (PLS_HOLD > 1) ? $clog2(PLS_HOLD) : 1;
    localparam int unsigned   SDW       = NUM_CH * DW;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(PLS_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        ACTIVE,
        COMMIT
    } state_e;

    state_e                 state_q,  state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic [AW-1:0]          addr_q,   addr_d;
    logic [DW-1:0]          data_q,   data_d;
    logic [SDW-1:0]         st_q,     st_d;
    logic [DW-1:0]          pls_q,    pls_d;
    logic                   plsv_q,   plsv_d;
    logic [HCW-1:0]         cnt_q,    cnt_d;
    logic [NUM_CH-1:0]      upd_q,    upd_d;
    logic                   err_q,    err_d;

    logic          nwr_gbl;
    logic          s_wr;
    logic          prime_ok;
    logic [AW-1:0] ch_off;
    logic          hit_state;

    assign nwr_gbl  = bus.WR | bus.CS;
    assign s_wr     = sync_q[SYNC_STAGES-1];
    // The chain resets to 1, so WAIT_HIGH trusts s_wr only once it holds a post-reset sample.
    assign prime_ok = prime_q[SYNC_STAGES-1];

    assign ch_off    = addr_q - STATE_BASE;
    assign hit_state = (addr_q >= STATE_BASE) && (ch_off < AW'(NUM_CH));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        st_d    = st_q;
        pls_d   = pls_q;
        plsv_d  = plsv_q;
        cnt_d   = cnt_q;
        upd_d   = '0;
        err_d   = err_q;

        // Pulse hold; a pulse commit below overrides this (retrigger).
        if (plsv_q) begin
            if (cnt_q == '0) begin
                pls_d  = '0;
                plsv_d = 1'b0;
            end else begin
                cnt_d = cnt_q - HCW'(1);
            end
        end

        case (state_q)
            WAIT_HIGH: begin
                if (s_wr && prime_ok) state_d = IDLE;
            end
            IDLE: begin
                if (!s_wr) state_d = ACTIVE;
            end
            ACTIVE: begin
                addr_d = bus.MCUportL;
                data_d = bus.Din;
                if (s_wr) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (hit_state) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (ch_off == AW'(i)) begin
                            st_d[i*DW +: DW] = data_q;
                            upd_d[i]         = 1'b1;
                        end
                    end
                end else if (addr_q == PLS_ADDR) begin
                    pls_d  = data_q;
                    plsv_d = 1'b1;
                    cnt_d  = HOLD_LOAD;
                end else if (addr_q == CLR_ADDR) begin
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= WAIT_HIGH;
            sync_q  <= '1;
            prime_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            st_q    <= '0;
            pls_q   <= '0;
            plsv_q  <= 1'b0;
            cnt_q   <= '0;
            upd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], nwr_gbl};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            addr_q  <= addr_d;
            data_q  <= data_d;
            st_q    <= st_d;
            pls_q   <= pls_d;
            plsv_q  <= plsv_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign bus.gStateCmd = st_q;
    assign bus.gPlsCmd   = pls_q;
    assign bus.pls_valid = plsv_q;
    assign bus.state_upd = upd_q;
    assign bus.wr_err    = err_q;

endmodule
